veda_master: RTL and testbench

//  Initiator that drives the veda register-file port (mode/we/addr_a/addr_b/data_in, data_out).

---
 rtl/veda_master_pkg.sv | 25 ++
 rtl/veda_master_if.sv | 53 +++++
 rtl/veda_cmd_fifo.sv | 41 ++++
 rtl/veda_master.sv | 188 ++++++++++++++++++
 tb/tb_veda_master.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/veda_master_pkg.sv
// Shared types and defaults for the veda register-file initiator.
package veda_master_pkg;

    localparam int unsigned VEDA_AW = 5;
    localparam int unsigned VEDA_DW = 32;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Width of one buffered command: op + addr_a + addr_b + data.
    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 1 + 2 * aw + dw;
    endfunction

endpackage

// File: rtl/veda_master_if.sv
// Command, response and veda-bus signals of the veda initiator.
// Stats counters are present only when VEDA_MASTER_STATS_EN is defined.
interface veda_master_if #(
    parameter int unsigned AW = veda_master_pkg::VEDA_AW,
    parameter int unsigned DW = veda_master_pkg::VEDA_DW
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_addr_a;
    logic [AW-1:0] cmd_addr_b;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          v_mode;
    logic          v_we;
    logic [AW-1:0] v_addr_a;
    logic [AW-1:0] v_addr_b;
    logic [DW-1:0] v_data_in;
    logic [DW-1:0] v_data_out;
    logic          busy;
`ifdef VEDA_MASTER_STATS_EN
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, v_data_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr,
        output v_mode, v_we, v_addr_a, v_addr_b, v_data_in, busy, wr_count, rd_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, v_data_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr,
        input  v_mode, v_we, v_addr_a, v_addr_b, v_data_in, busy, wr_count, rd_count
    );
`else
    modport master (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, v_data_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr,
        output v_mode, v_we, v_addr_a, v_addr_b, v_data_in, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, v_data_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr,
        input  v_mode, v_we, v_addr_a, v_addr_b, v_data_in, busy
    );
`endif

endinterface

// File: rtl/veda_cmd_fifo.sv
// Synchronous command FIFO; head is read combinationally, occupancy is registered.
module veda_cmd_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/veda_master.sv
// Initiator for the veda register-file port: buffers commands, issues them in order,
// returns read data. Define VEDA_MASTER_STATS_EN to add wr_count/rd_count outputs.
module veda_master
    import veda_master_pkg::*;
#(
    parameter int unsigned AW     = VEDA_AW,
    parameter int unsigned DW     = VEDA_DW,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    veda_master_if.master bus
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned LATW = $clog2(RD_LAT + 1);
    localparam int unsigned CMDW = cmd_width(AW, DW);

    typedef struct packed {
        op_e           op;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic          we;
        logic          mode;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data_in;
    } vbus_t;

    state_e          state_q, state_d;
    vbus_t           bus_q, bus_d;
    logic [LATW-1:0] lat_q, lat_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q;
    logic [AW-1:0]   rsp_addr_q;
    logic            cmd_ready_q;
    logic            busy_q;
    logic            capture;
    logic            push;
    logic            pop;
    logic            fifo_empty_c;
    cmd_t            push_cmd;
    cmd_t            head_c;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_nxt;

    assign push      = bus.cmd_valid & cmd_ready_q;
    assign push_cmd  = {op_e'(bus.cmd_op), bus.cmd_addr_a, bus.cmd_addr_b, bus.cmd_data};
    assign fifo_empty_c = (count == '0);
    assign count_nxt = count + CNTW'(push) - CNTW'(pop);

    veda_cmd_fifo #(
        .W     (CMDW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata_c (head_c),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state plus next value of the registered bus; the head is popped on entry to ISSUE.
    always_comb begin
        state_d     = state_q;
        bus_d       = '0;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        pop         = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    state_d = ST_ISSUE;
                    pop     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus_q.mode) begin
                    state_d = ST_WAIT;
                    bus_d   = bus_q;
                    lat_d   = '0;
                end else if (!fifo_empty_c) begin
                    pop = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == LATW'(RD_LAT - 1)) begin
                    state_d = ST_CAPTURE;
                    capture = 1'b1;
                end else begin
                    bus_d = bus_q;
                    lat_d = lat_q + LATW'(1);
                end
            end
            ST_CAPTURE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty_c) begin
                        state_d = ST_ISSUE;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            bus_d.we      = (head_c.op == OP_WRITE);
            bus_d.mode    = (head_c.op == OP_READ);
            bus_d.addr_a  = head_c.addr_a;
            bus_d.addr_b  = head_c.addr_b;
            bus_d.data_in = (head_c.op == OP_WRITE) ? head_c.data : '0;
        end
    end

    // cmd_ready stays low for the cycle in which a full FIFO is popped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_q       <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bus_q       <= bus_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            if (capture) begin
                rsp_data_q <= bus.v_data_out;
                rsp_addr_q <= bus_q.addr_a;
            end
            cmd_ready_q <= (count_nxt != CNTW'(DEPTH)) && (count != CNTW'(DEPTH));
            busy_q      <= (count_nxt != '0) || (state_d != ST_IDLE);
        end
    end

`ifdef VEDA_MASTER_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else if (pop) begin
            if (head_c.op == OP_WRITE) wr_count_q <= wr_count_q + 16'd1;
            else                       rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign bus.wr_count = wr_count_q;
    assign bus.rd_count = rd_count_q;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.v_we      = bus_q.we;
    assign bus.v_mode    = bus_q.mode;
    assign bus.v_addr_a  = bus_q.addr_a;
    assign bus.v_addr_b  = bus_q.addr_b;
    assign bus.v_data_in = bus_q.data_in;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_veda_master.sv
// Bench for veda_master: directed scenarios plus random traffic against an in-order
// command/response scoreboard and a behavioural veda register file.
module tb_veda_master;

    localparam int unsigned AW     = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    veda_master_if #(.AW(AW), .DW(DW)) bus ();

    veda_master #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural veda register file: write on we, registered read on mode.
    logic [DW-1:0] vmem [2**AW] = '{default: '0};
    logic [DW-1:0] v_dout_q = '0;
    always @(posedge clk) begin
        if (bus.v_we)   vmem[bus.v_addr_a] <= bus.v_data_in;
        if (bus.v_mode) v_dout_q <= vmem[bus.v_addr_a];
    end
    assign bus.v_data_out = v_dout_q;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct packed {
        logic          op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [DW-1:0] d;
    } cmd_s;

    cmd_s                exp_cmd_q [$];
    logic [DW+AW-1:0]    exp_rsp_q [$];
    logic [DW-1:0]       ref_mem [2**AW] = '{default: '0};
    logic                mon_en = 1'b0;
    int unsigned         n_acc, n_iss, n_wr, n_rd;
    int unsigned         we_cycles, we_run, last_we_run, mode_run;
    logic                prev_mode, rsp_hold;
    logic [DW+AW-1:0]    held_rsp, last_rsp, cur_rsp;
    logic [63:0]         obus, rd_bus;
    cmd_s                mon_c;

    function automatic logic [63:0] exp_bus(input cmd_s c);
        return 64'({~c.op, c.op, c.a, c.b, c.op ? {DW{1'b0}} : c.d});
    endfunction

    task automatic clear_model();
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        n_acc = 0; n_iss = 0; n_wr = 0; n_rd = 0;
        we_run = 0; mode_run = 0; prev_mode = 1'b0; rsp_hold = 1'b0;
    endtask

    // Monitor/scoreboard: outputs sampled mid-cycle, events complete at the next posedge.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            obus = 64'({bus.v_we, bus.v_mode, bus.v_addr_a, bus.v_addr_b, bus.v_data_in});
            if (bus.v_we) begin
                we_cycles++;
                we_run++;
                check_eq("we_while_rsp", 64'(bus.rsp_valid), 64'd0);
                if (exp_cmd_q.size() == 0) check_eq("unexpected_write", 64'd1, 64'd0);
                else begin
                    mon_c = exp_cmd_q.pop_front();
                    n_iss++; n_wr++;
                    check_eq("write_bus", obus, exp_bus(mon_c));
                    if (!mon_c.op) ref_mem[mon_c.a] = mon_c.d;
                end
            end else if (we_run != 0) begin
                last_we_run = we_run;
                we_run = 0;
            end
            if (bus.v_mode && !prev_mode) begin
                mode_run = 1;
                rd_bus = obus;
                if (exp_cmd_q.size() == 0) check_eq("unexpected_read", 64'd1, 64'd0);
                else begin
                    mon_c = exp_cmd_q.pop_front();
                    n_iss++; n_rd++;
                    check_eq("read_bus", obus, exp_bus(mon_c));
                    if (mon_c.op) exp_rsp_q.push_back({ref_mem[mon_c.a], mon_c.a});
                end
            end else if (bus.v_mode) begin
                mode_run++;
                check_eq("read_hold", obus, rd_bus);
            end else if (prev_mode) begin
                check_eq("read_len", 64'(mode_run), 64'(1 + RD_LAT));
            end
            if (!bus.v_we && !bus.v_mode) check_eq("idle_bus", obus, 64'd0);
            prev_mode = bus.v_mode;

            if (bus.rsp_valid) begin
                cur_rsp = {bus.rsp_data, bus.rsp_addr};
                if (rsp_hold) check_eq("rsp_stable", 64'(cur_rsp), 64'(held_rsp));
                if (bus.rsp_ready) begin
                    if (exp_rsp_q.size() == 0) check_eq("unexpected_rsp", 64'd1, 64'd0);
                    else check_eq("rsp_data", 64'(cur_rsp), 64'(exp_rsp_q.pop_front()));
                    last_rsp = cur_rsp;
                    rsp_hold = 1'b0;
                end else begin
                    held_rsp = cur_rsp;
                    rsp_hold = 1'b1;
                end
            end else begin
                rsp_hold = 1'b0;
            end

            if (bus.cmd_valid && bus.cmd_ready) begin
                check_eq("fifo_room", 64'((n_acc - n_iss) < DEPTH), 64'd1);
                n_acc++;
                exp_cmd_q.push_back({bus.cmd_op, bus.cmd_addr_a, bus.cmd_addr_b, bus.cmd_data});
            end
        end
    end

    task automatic push_cmd(input logic op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [DW-1:0] d);
        int g = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr_a = a;
        bus.cmd_addr_b = b;
        bus.cmd_data   = d;
        @(negedge clk);
        while (!bus.cmd_ready && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (g >= 200) check_eq("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        @(negedge clk);
        while (!(exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0 && !bus.busy && !bus.rsp_valid)
               && g < 500) begin
            g++;
            @(negedge clk);
        end
        check_eq({tag, "_drain"}, 64'(g < 500), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned w0;
        int g;
        logic acc;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_addr_a = '0;
        bus.cmd_addr_b = '0;
        bus.cmd_data   = '0;
        bus.rsp_ready  = 1'b0;
        we_cycles = 0; last_we_run = 0;
        clear_model();

        // 1: reset values
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", 64'({bus.cmd_ready, bus.rsp_valid, bus.v_mode, bus.v_we, bus.busy,
                                    bus.rsp_addr, bus.v_addr_a, bus.v_addr_b}), 64'd0);
        check_eq("reset_data", 64'({bus.rsp_data, bus.v_data_in}), 64'd0);
`ifdef VEDA_MASTER_STATS_EN
        check_eq("reset_stats", 64'({bus.wr_count, bus.rd_count}), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_reset_ready_busy", 64'({bus.cmd_ready, bus.busy}), 64'b10);
        @(posedge clk);
        #1;

        // 2: single write
        bus.rsp_ready = 1'b1;
        w0 = we_cycles;
        push_cmd(1'b0, 5'd3, 5'd4, 32'd10);
        wait_idle("s2");
        check_eq("s2_we_cycles", 64'(we_cycles - w0), 64'd1);

        // 3: write then read of the same address
        push_cmd(1'b0, 5'd3, 5'd4, 32'd11);
        push_cmd(1'b1, 5'd3, 5'd4, 32'd0);
        wait_idle("s3");
        check_eq("s3_rsp", 64'(last_rsp), 64'({32'd11, 5'd3}));

        // 4: stalled read holds back queued writes
        bus.rsp_ready = 1'b0;
        push_cmd(1'b1, 5'd3, 5'd4, 32'd0);
        for (int i = 0; i < 4; i++) push_cmd(1'b0, AW'(8 + i), AW'(i), DW'(20 + i));
        @(negedge clk);
        check_eq("s4_full_ready", 64'(bus.cmd_ready), 64'd0);
        w0 = we_cycles;
        tick(6);
        check_eq("s4_stall_no_we", 64'(we_cycles - w0), 64'd0);
        check_eq("s4_rsp_pending", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        wait_idle("s4");
        check_eq("s4_burst", 64'(last_we_run), 64'd4);
        check_eq("s4_we_total", 64'(we_cycles - w0), 64'd4);

        // 5: back-to-back writes
        for (int i = 1; i <= 4; i++) push_cmd(1'b0, AW'(16 + i), AW'(i), DW'(i));
        wait_idle("s5");
        check_eq("s5_burst", 64'(last_we_run), 64'd4);
        check_eq("s5_busy", 64'(bus.busy), 64'd0);

        // 6: reset while a read is waiting, with a write still queued
        push_cmd(1'b1, 5'd5, 5'd6, 32'd0);
        push_cmd(1'b0, 5'd7, 5'd7, 32'd99);
        g = 0;
        while (!bus.v_mode && g < 20) begin
            g++;
            @(negedge clk);
        end
        check_eq("s6_read_seen", 64'(bus.v_mode), 64'd1);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("s6_reset_ctrl", 64'({bus.v_we, bus.v_mode, bus.rsp_valid, bus.busy, bus.cmd_ready}),
                 64'd0);
`ifdef VEDA_MASTER_STATS_EN
        check_eq("s6_stats", 64'({bus.wr_count, bus.rd_count}), 64'd0);
`endif
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        w0 = we_cycles;
        tick(10);
        check_eq("s6_no_we", 64'(we_cycles - w0), 64'd0);
        check_eq("s6_quiet", 64'({bus.busy, bus.rsp_valid, bus.cmd_ready}), 64'b001);

        // Random traffic, clustered addresses for read-after-write hits
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = bus.cmd_valid && bus.cmd_ready;
            @(posedge clk);
            #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!bus.cmd_valid || acc) begin
                bus.cmd_valid  = ($urandom_range(0, 9) < 6);
                bus.cmd_op     = 1'($urandom_range(0, 1));
                bus.cmd_addr_a = AW'($urandom_range(0, 7));
                bus.cmd_addr_b = AW'($urandom);
                bus.cmd_data   = $urandom;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle("rand");
        check_eq("rand_all_issued", 64'(n_iss), 64'(n_acc));
`ifdef VEDA_MASTER_STATS_EN
        check_eq("rand_wr_count", 64'(bus.wr_count), 64'(16'(n_wr)));
        check_eq("rand_rd_count", 64'(bus.rd_count), 64'(16'(n_rd)));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
